// File: rtl/writebooster_wr_sink.sv
// writebooster_wr_sink: AXI4 write slave sink that checks INCR bursts against an incrementing-word reference
// Ports: ACLK/ARESETN clock and sync active-low reset; S_AXI_AW*/W*/B* AXI4 write slave channels;
//   CLEAR_STATS pulse zeroes stats and reloads the reference; DATA_ERR/PROTO_ERR sticky errors;
//   BURST_CNT/BEAT_CNT saturating completed-burst and accepted-beat counters.
module writebooster_wr_sink #(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter logic [63:0] C_EXP_SEED         = 64'd1,
  parameter int unsigned C_WSTALL_PERIOD    = 0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic                            CLEAR_STATS,
  output logic                            DATA_ERR,
  output logic                            PROTO_ERR,
  output logic [31:0]                     BURST_CNT,
  output logic [31:0]                     BEAT_CNT
);
  localparam int unsigned SW  = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(SW);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] SEED = C_EXP_SEED[C_S_AXI_DATA_WIDTH-1:0];
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic awready_q, awready_d, slverr_q, slverr_d, stall_q, stall_d;
  logic data_err_q, data_err_d, proto_err_q, proto_err_d;
  logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] exp_q, exp_d;
  logic [31:0] beat_cnt_q, beat_cnt_d, burst_cnt_q, burst_cnt_d, stall_cnt_q, stall_cnt_d;
  logic aw_hs, beat, b_hs, mism, stall_hit, unused_addr;
  assign unused_addr   = ^S_AXI_AWADDR;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = state_q == DATA && !stall_q;
  assign S_AXI_BVALID  = state_q == RESP;
  assign S_AXI_BID     = id_q;
  assign S_AXI_BRESP   = state_q == RESP && slverr_q ? 2'b10 : 2'b00;
  assign DATA_ERR      = data_err_q;
  assign PROTO_ERR     = proto_err_q;
  assign BURST_CNT     = burst_cnt_q;
  assign BEAT_CNT      = beat_cnt_q;
  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < SW; i++)
      mism = mism | (S_AXI_WSTRB[i] && S_AXI_WDATA[8*i +: 8] != exp_q[8*i +: 8]);
    aw_hs       = state_q == IDLE && awready_q && S_AXI_AWVALID;
    beat        = S_AXI_WREADY && S_AXI_WVALID;
    b_hs        = state_q == RESP && S_AXI_BREADY;
    stall_hit   = C_WSTALL_PERIOD != 0 && beat && stall_cnt_q == 32'(C_WSTALL_PERIOD - 1);
    state_d     = aw_hs ? DATA : (beat && (S_AXI_WLAST || beat_q == len_q)) ? RESP : b_hs ? IDLE : state_q;
    awready_d   = state_d == IDLE;
    id_d        = aw_hs ? S_AXI_AWID : id_q;
    len_d       = aw_hs ? S_AXI_AWLEN : len_q;
    beat_d      = aw_hs ? 8'd0 : beat ? beat_q + 8'd1 : beat_q;
    // WLAST must be high exactly on the beat whose index equals AWLEN
    slverr_d    = aw_hs ? (S_AXI_AWBURST != 2'b01 || S_AXI_AWSIZE != 3'(LSB) || S_AXI_AWADDR[LSB-1:0] != '0)
                        : slverr_q | (beat && (S_AXI_WLAST != (beat_q == len_q)));
    stall_d     = stall_hit;
    stall_cnt_d = stall_hit ? 32'd0 : (beat && C_WSTALL_PERIOD != 0) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    exp_d       = CLEAR_STATS ? SEED : beat ? exp_q + 1'b1 : exp_q;
    beat_cnt_d  = CLEAR_STATS ? 32'd0 : beat_cnt_q + 32'(beat && beat_cnt_q != '1);
    burst_cnt_d = CLEAR_STATS ? 32'd0 : burst_cnt_q + 32'(b_hs && burst_cnt_q != '1);
    data_err_d  = !CLEAR_STATS && (data_err_q || (beat && mism));
    proto_err_d = !CLEAR_STATS && (proto_err_q || (state_q == DATA && state_d == RESP && slverr_d));
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      slverr_q    <= 1'b0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      exp_q       <= SEED;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      data_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      id_q        <= id_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      slverr_q    <= slverr_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      exp_q       <= exp_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      data_err_q  <= data_err_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule
